// File: rtl/i2s_frame_buffer.sv
// Ping-pong frame buffer between the I2S receiver and the spectrum stage.
// Collects one channel into FRAME_LEN-sample frames and streams them out with sop/eop markers.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// W_FILL   | writer stores accepted samples into the current write bank
// W_WAIT   | both banks full; accepted samples are dropped and counted
// R_IDLE   | reader waits for a full bank (bank 0 preferred)
// R_STREAM | reader presents the selected bank, one beat per handshake
module i2s_frame_buffer #(
    parameter int DATA_W    = 24,
    parameter int FRAME_LEN = 256,
    parameter int ADDR_W    = 8,
    parameter int CHANNEL   = 0
) (
    input  logic              MCLK,
    input  logic              RESET,
    input  logic              in_valid,
    input  logic              in_channel,
    input  logic [DATA_W-1:0] in_data,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_sop,
    output logic              out_eop,
    output logic              overflow,
    input  logic              overflow_clr,
    output logic [15:0]       drop_count
);

    typedef enum logic {W_FILL, W_WAIT} wstate_t;
    typedef enum logic {R_IDLE, R_STREAM} rstate_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FRAME_LEN - 1);
    localparam logic              CH_SEL   = 1'(CHANNEL);

    logic [DATA_W-1:0] mem [0:2*FRAME_LEN-1];

    wstate_t           wstate, wstate_nxt;
    rstate_t           rstate, rstate_nxt;
    logic              wbank;
    logic [ADDR_W-1:0] widx;
    logic [1:0]        bank_full;
    logic              rbank;
    logic [ADDR_W-1:0] ridx;

    logic accept, wr_en, wr_last, w_toggle, drop;
    logic rd_start, rd_release, rd_sel, other_free;

    assign accept  = in_valid && (in_channel == CH_SEL);
    assign wr_last = (widx == LAST_IDX);
    assign rd_sel  = ~bank_full[0];

    always_comb begin
        wstate_nxt = wstate;
        rstate_nxt = rstate;
        wr_en      = 1'b0;
        w_toggle   = 1'b0;
        drop       = 1'b0;
        rd_start   = 1'b0;
        rd_release = 1'b0;

        case (rstate)
            R_IDLE: begin
                if (|bank_full) begin
                    rd_start   = 1'b1;
                    rstate_nxt = R_STREAM;
                end
            end
            R_STREAM: begin
                if (out_valid && out_ready && out_eop) begin
                    rd_release = 1'b1;
                    rstate_nxt = R_IDLE;
                end
            end
            default: rstate_nxt = R_IDLE;
        endcase

        // A bank released by the reader this cycle is already usable by the writer.
        other_free = !bank_full[~wbank] || (rd_release && (rbank == ~wbank));

        case (wstate)
            W_FILL: begin
                if (accept) begin
                    wr_en = 1'b1;
                    if (wr_last) begin
                        if (other_free) w_toggle   = 1'b1;
                        else            wstate_nxt = W_WAIT;
                    end
                end
            end
            W_WAIT: begin
                drop = accept;
                if (other_free) begin
                    w_toggle   = 1'b1;
                    wstate_nxt = W_FILL;
                end
            end
            default: wstate_nxt = W_FILL;
        endcase
    end

    always_ff @(posedge MCLK or negedge RESET) begin
        if (!RESET) begin
            wstate    <= W_FILL;
            rstate    <= R_IDLE;
            wbank     <= 1'b0;
            widx      <= '0;
            bank_full <= '0;
        end else begin
            wstate <= wstate_nxt;
            rstate <= rstate_nxt;
            if (wr_en)    widx  <= widx + ADDR_W'(1);
            if (w_toggle) wbank <= ~wbank;
            if (wr_en && wr_last) bank_full[wbank] <= 1'b1;
            if (rd_release)       bank_full[rbank] <= 1'b0;
        end
    end

    always_ff @(posedge MCLK) begin
        if (wr_en) mem[{wbank, widx}] <= in_data;
    end

    // out_data is the registered RAM read; it only advances on start or on a transfer.
    always_ff @(posedge MCLK or negedge RESET) begin
        if (!RESET) begin
            out_valid <= 1'b0;
            out_sop   <= 1'b0;
            out_eop   <= 1'b0;
            out_data  <= '0;
            rbank     <= 1'b0;
            ridx      <= '0;
        end else if (rd_start) begin
            out_data  <= mem[{rd_sel, {ADDR_W{1'b0}}}];
            out_valid <= 1'b1;
            out_sop   <= 1'b1;
            out_eop   <= (LAST_IDX == '0);
            rbank     <= rd_sel;
            ridx      <= ADDR_W'(1);
        end else if (rd_release) begin
            out_valid <= 1'b0;
            out_sop   <= 1'b0;
            out_eop   <= 1'b0;
        end else if (out_valid && out_ready) begin
            out_data <= mem[{rbank, ridx}];
            out_sop  <= 1'b0;
            out_eop  <= (ridx == LAST_IDX);
            ridx     <= ridx + ADDR_W'(1);
        end
    end

    always_ff @(posedge MCLK or negedge RESET) begin
        if (!RESET) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (overflow_clr) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_i2s_frame_buffer.sv
// Directed bench for i2s_frame_buffer: expected beats are queued as samples are fed
// and popped by a monitor when the DUT transfers a beat.
module tb_i2s_frame_buffer;

    logic        MCLK = 1'b0;
    logic        RESET = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_channel = 1'b0;
    logic [23:0] in_data = '0;
    logic        out_ready = 1'b0;
    logic        out_valid;
    logic [23:0] out_data;
    logic        out_sop;
    logic        out_eop;
    logic        overflow;
    logic        overflow_clr = 1'b0;
    logic [15:0] drop_count;

    int total = 0;
    int bad   = 0;

    logic [25:0] exp_q[$];
    int          n_sop = 0;
    int          n_eop = 0;
    int          ncyc = 0;
    int          sop_cyc = 0;
    int          eop_cyc = 0;

    i2s_frame_buffer #(.DATA_W(24), .FRAME_LEN(256), .ADDR_W(8), .CHANNEL(0)) dut (
        .MCLK(MCLK), .RESET(RESET), .in_valid(in_valid), .in_channel(in_channel),
        .in_data(in_data), .out_ready(out_ready), .out_valid(out_valid),
        .out_data(out_data), .out_sop(out_sop), .out_eop(out_eop),
        .overflow(overflow), .overflow_clr(overflow_clr), .drop_count(drop_count)
    );

    always #5 MCLK = ~MCLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge MCLK);
        #1;
    endtask

    task automatic send(input logic ch, input logic [23:0] d);
        in_valid   = 1'b1;
        in_channel = ch;
        in_data    = d;
        cyc();
        in_valid   = 1'b0;
    endtask

    task automatic feed(input int first, input int n, input bit interleave);
        for (int i = 0; i < n; i++) begin
            if (interleave) send(1'b1, 24'hFFFFFF);
            send(1'b0, 24'(first + i));
        end
    endtask

    task automatic push_frame(input int first);
        for (int i = 0; i < 256; i++)
            exp_q.push_back({(i == 0), (i == 255), 24'(first + i)});
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            cyc();
            n++;
        end
        check(tag, 32'(exp_q.size()), 32'd0);
        repeat (4) cyc();
        @(negedge MCLK);
        check({tag, "_quiet"}, {31'd0, out_valid}, 32'd0);
        cyc();
    endtask

    // Monitor: scoreboard pops, stall stability, and flag qualification.
    initial begin
        logic        stall_prev = 1'b0;
        logic [25:0] prev_word = '0;
        logic [25:0] e;
        forever begin
            @(negedge MCLK);
            if (!RESET) begin
                stall_prev = 1'b0;
            end else begin
                ncyc++;
                if (!out_valid) check("flags_idle", {30'd0, out_sop, out_eop}, 32'd0);
                if (stall_prev && out_valid)
                    check("stall_hold", {6'd0, out_sop, out_eop, out_data}, {6'd0, prev_word});
                if (out_valid && out_ready) begin
                    total++;
                    assert (exp_q.size() != 0) else begin
                        bad++;
                        $error("FAIL unexpected_beat: observed data=%0h expected no beat", out_data);
                    end
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("beat", {6'd0, out_sop, out_eop, out_data}, {6'd0, e});
                    end
                    if (out_sop) begin n_sop++; sop_cyc = ncyc; end
                    if (out_eop) begin n_eop++; eop_cyc = ncyc; end
                end
                stall_prev = out_valid && !out_ready;
                prev_word  = {out_sop, out_eop, out_data};
            end
        end
    end

    initial begin
        int s0, e0;

        // Reset held with in_valid toggling
        for (int i = 0; i < 5; i++) begin
            in_valid = (i % 2 == 0);
            in_data  = 24'h777777;
            @(negedge MCLK);
            check("rst_valid", {31'd0, out_valid}, 32'd0);
            check("rst_ovf", {31'd0, overflow}, 32'd0);
            check("rst_drop", 32'(drop_count), 32'd0);
        end
        cyc();
        in_valid = 1'b0;
        RESET    = 1'b1;
        cyc();

        // First frame after reset
        out_ready = 1'b1;
        push_frame(5000);
        feed(5000, 256, 1'b0);
        drain("post_reset_frame");

        // Single interleaved frame, latency and throughput
        push_frame(1);
        feed(1, 256, 1'b1);
        @(negedge MCLK);
        check("lat_early", {31'd0, out_valid}, 32'd0);
        @(negedge MCLK);
        check("lat_valid", {31'd0, out_valid}, 32'd1);
        check("lat_sop", {31'd0, out_sop}, 32'd1);
        cyc();
        drain("single_frame");
        check("no_bubbles", 32'(eop_cyc - sop_cyc), 32'd255);
        check("single_ovf", {31'd0, overflow}, 32'd0);

        // Backpressure with random ready
        out_ready = 1'b0;
        s0 = n_sop;
        e0 = n_eop;
        push_frame(1);
        feed(1, 256, 1'b0);
        for (int n = 0; n < 3000 && exp_q.size() != 0; n++) begin
            out_ready = 1'($urandom_range(0, 1));
            cyc();
        end
        out_ready = 1'b1;
        drain("backpressure");
        check("bp_sop_once", 32'(n_sop - s0), 32'd1);
        check("bp_eop_once", 32'(n_eop - e0), 32'd1);

        // Overflow
        out_ready = 1'b0;
        push_frame(1);
        push_frame(257);
        feed(1, 512, 1'b0);
        @(negedge MCLK);
        check("ovf_before", {31'd0, overflow}, 32'd0);
        cyc();
        send(1'b0, 24'd513);
        @(negedge MCLK);
        check("ovf_set", {31'd0, overflow}, 32'd1);
        check("ovf_drop1", 32'(drop_count), 32'd1);
        cyc();
        feed(514, 255, 1'b1);
        @(negedge MCLK);
        check("ovf_drop256", 32'(drop_count), 32'd256);
        cyc();
        overflow_clr = 1'b1;
        send(1'b0, 24'd769);
        overflow_clr = 1'b0;
        @(negedge MCLK);
        check("clr_wins_ovf", {31'd0, overflow}, 32'd0);
        check("clr_wins_drop", 32'(drop_count), 32'd0);
        cyc();
        send(1'b0, 24'd770);
        @(negedge MCLK);
        check("drop_after_clr", 32'(drop_count), 32'd1);
        cyc();
        out_ready = 1'b1;
        drain("ovf_two_frames");
        push_frame(1000);
        feed(1000, 256, 1'b0);
        drain("ovf_resume");
        check("ovf_drop_kept", 32'(drop_count), 32'd1);
        overflow_clr = 1'b1;
        cyc();
        overflow_clr = 1'b0;
        @(negedge MCLK);
        check("clr_only", {15'd0, overflow, drop_count}, 32'd0);
        cyc();

        // Writer finishes frame 2 in the cycle frame 1's eop transfers
        out_ready = 1'b0;
        push_frame(2000);
        push_frame(3000);
        feed(2000, 256, 1'b0);
        feed(3000, 255, 1'b0);
        out_ready = 1'b1;
        repeat (255) cyc();
        send(1'b0, 24'd3255);
        @(negedge MCLK);
        check("same_rel_gap", {31'd0, out_valid}, 32'd0);
        @(negedge MCLK);
        check("same_rel_next", {30'd0, out_valid, out_sop}, 32'd3);
        check("same_rel_drop", 32'(drop_count), 32'd0);
        cyc();
        drain("same_release");

        // Reset while a frame is streaming and the next is half written
        out_ready = 1'b0;
        push_frame(4000);
        feed(4000, 256, 1'b0);
        feed(5000, 100, 1'b0);
        @(negedge MCLK);
        check("mid_valid", {31'd0, out_valid}, 32'd1);
        cyc();
        RESET = 1'b0;
        #1;
        check("async_drop", {31'd0, out_valid}, 32'd0);
        exp_q.delete();
        cyc();
        RESET = 1'b1;
        cyc();
        out_ready = 1'b1;
        push_frame(6000);
        feed(6000, 256, 1'b0);
        drain("after_mid_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
